pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Pipeline hazard and stall controller for the 5-stage RISC-V core. It drives the write-enable (stall) and flush controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It resolves three conditions: load-use hazards, taken-branch/JAL redirects, and I/D cache miss stalls. It also keeps a pending-redirect flag, a stall watchdog and performance counters.

## Interface
Parameters:
- TIMEOUT, 1024, consecutive memory-stall cycles that set timeout_o (min 2)
- CNT_W, 32, width of performance counters

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- ID_EX_MemRead_i  in  1  instruction in EX is a load
- ID_EX_Rd_i  in  5  destination register of instruction in EX
- IF_ID_Rs1_i, IF_ID_Rs2_i  in  5 each  source registers of instruction in ID
- ID_UseRs1_i, ID_UseRs2_i  in  1 each  ID instruction actually reads rs1/rs2
- Redirect_i  in  1  one-cycle pulse from EX: branch taken or JAL
- ICache_stall_i, DCache_stall_i  in  1 each  cache miss in progress
- PC_write_o, IF_ID_write_o, ID_EX_write_o, EX_MEM_write_o, MEM_WB_write_o  out  1 each  stage-register update enables
- IF_ID_flush_o, ID_EX_flush_o  out  1 each  zero the stage register (bubble)
- Redirect_apply_o  out  1  PC mux selects branch target this cycle
- timeout_o  out  1  sticky watchdog flag
- stall_cnt_o  out  CNT_W  total stalled/bubbled cycles
- flush_cnt_o  out  CNT_W  total redirects applied

## Operation
- Registered state: pending_r, mstall_cnt_r (ceil(log2(TIMEOUT+1)) bits), timeout_r, stall_cnt_r, flush_cnt_r.
- mem_stall = ICache_stall_i | DCache_stall_i.
- redir = Redirect_i | pending_r.
- load_use = ID_EX_MemRead_i & (ID_EX_Rd_i != 0) & ((ID_UseRs1_i & Rd==Rs1) | (ID_UseRs2_i & Rd==Rs2)).
- Priority per cycle is mem_stall > redir > load_use > normal.
- MEM_STALL:
  - All five write enables are 0.
  - Both flushes are 0.
  - Redirect_apply_o is 0.
  - If Redirect_i is high, pending_r <= 1.
- REDIRECT (no mem_stall, redir):
  - All write enables are 1.
  - IF_ID_flush_o = 1 and ID_EX_flush_o = 1.
  - Redirect_apply_o = 1.
  - pending_r <= 0.
  - flush_cnt_r increments.
  - A simultaneous load_use is ignored, because the dependent instruction is squashed.
- LOAD_USE (no mem_stall, no redir):
  - PC_write_o = 0 and IF_ID_write_o = 0.
  - ID_EX_write_o = 1 with ID_EX_flush_o = 1, which inserts a bubble.
  - EX_MEM_write_o = 1 and MEM_WB_write_o = 1.
- NORMAL: all write enables are 1, flushes are 0, Redirect_apply_o is 0.
- Flush takes precedence over write in the stage register, so a flushed register loads zeros.
- stall_cnt_r increments in MEM_STALL and LOAD_USE cycles.
- Both counters wrap modulo 2^CNT_W.
- Watchdog:
  - mstall_cnt_r increments each MEM_STALL cycle, saturating at TIMEOUT.
  - mstall_cnt_r clears on any cycle without mem_stall.
  - timeout_r <= 1 when mstall_cnt_r reaches TIMEOUT.
  - timeout_r stays set until reset.
  - timeout_o does not alter any stall behaviour.

## Timing
- All control outputs are combinational from the current inputs and registered state, so they are valid in the same cycle.
- Counters, pending_r and timeout_r update on the rising edge.
- While rst_i is high:
  - All write enables, flushes and Redirect_apply_o are forced to 0.
  - pending_r, mstall_cnt_r, timeout_r, stall_cnt_o and flush_cnt_o are 0.
- On rst_i deassertion, the first edge follows normal rules.
- Reset asserted mid-stall discards pending_r; no redirect is applied after reset.
- A load-use bubble lasts exactly 1 cycle. Next cycle the load is in MEM, so load_use drops without any state.
- A redirect pulse arriving during a stall is applied on the first cycle mem_stall is low (0 cycles later if the stall ends that same edge).
- A second Redirect_i while pending_r is set is merged (counted once).
- timeout_o rises on the edge after the TIMEOUT-th consecutive stall cycle.

## Test plan
- Load-use, rs1:
  - Stimulus: ID_EX_MemRead_i=1, ID_EX_Rd_i=5, IF_ID_Rs1_i=5, ID_UseRs1_i=1, all else 0.
  - Response: PC_write_o=0, IF_ID_write_o=0, ID_EX_flush_o=1, EX_MEM/MEM_WB write=1; stall_cnt_o goes 0→1.
- Load-use to x0:
  - Stimulus: Rd=0=Rs1, both used.
  - Response: no stall; all writes 1, stall_cnt_o stays 0.
- Redirect with simultaneous load-use:
  - Stimulus: Redirect_i=1 together with a load_use condition.
  - Response: IF_ID_flush_o=1, ID_EX_flush_o=1, PC_write_o=1, Redirect_apply_o=1; flush_cnt_o=1, stall_cnt_o=0.
- Redirect during miss:
  - Stimulus: DCache_stall_i=1 for 5 cycles, Redirect_i pulsed in cycle 2.
  - Response: all writes 0 for 5 cycles; cycle 6 Redirect_apply_o=1 with both flushes; flush_cnt_o=1, stall_cnt_o=5.
- Watchdog:
  - Stimulus: TIMEOUT=4, ICache_stall_i held 6 cycles.
  - Response: timeout_o=1 after the 4th edge, remains 1 after the stall clears.
- Reset mid-operation:
  - Stimulus: assert rst_i with pending_r=1 and counters nonzero.
  - Response: immediately all outputs 0; after release, no redirect is applied.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller for the 5-stage pipeline: load-use bubbles, redirects,
// cache-miss freezes, plus a stall watchdog and performance counters.
module pipe_hazard_ctrl #(
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ID_EX_MemRead_i,
    input  logic [4:0]       ID_EX_Rd_i,
    input  logic [4:0]       IF_ID_Rs1_i,
    input  logic [4:0]       IF_ID_Rs2_i,
    input  logic             ID_UseRs1_i,
    input  logic             ID_UseRs2_i,
    input  logic             Redirect_i,
    input  logic             ICache_stall_i,
    input  logic             DCache_stall_i,
    output logic             PC_write_o,
    output logic             IF_ID_write_o,
    output logic             ID_EX_write_o,
    output logic             EX_MEM_write_o,
    output logic             MEM_WB_write_o,
    output logic             IF_ID_flush_o,
    output logic             ID_EX_flush_o,
    output logic             Redirect_apply_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam int unsigned MW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        MODE_NORMAL,
        MODE_LOAD_USE,
        MODE_REDIRECT,
        MODE_MEM_STALL
    } mode_e;

    logic             pending_q, pending_d;
    logic [MW-1:0]    mstall_cnt_q, mstall_cnt_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic  mem_stall_c, redir_c, load_use_c;
    mode_e mode_c;

    // Cycle classification, highest priority first.
    always_comb begin
        mem_stall_c = ICache_stall_i | DCache_stall_i;
        redir_c     = Redirect_i | pending_q;
        load_use_c  = ID_EX_MemRead_i && (ID_EX_Rd_i != 5'd0) &&
                      ((ID_UseRs1_i && (ID_EX_Rd_i == IF_ID_Rs1_i)) ||
                       (ID_UseRs2_i && (ID_EX_Rd_i == IF_ID_Rs2_i)));
        if (mem_stall_c)     mode_c = MODE_MEM_STALL;
        else if (redir_c)    mode_c = MODE_REDIRECT;
        else if (load_use_c) mode_c = MODE_LOAD_USE;
        else                 mode_c = MODE_NORMAL;
    end

    // Control outputs and next state; reset forces every control low.
    always_comb begin
        PC_write_o       = 1'b0;
        IF_ID_write_o    = 1'b0;
        ID_EX_write_o    = 1'b0;
        EX_MEM_write_o   = 1'b0;
        MEM_WB_write_o   = 1'b0;
        IF_ID_flush_o    = 1'b0;
        ID_EX_flush_o    = 1'b0;
        Redirect_apply_o = 1'b0;
        pending_d        = pending_q;
        mstall_cnt_d     = '0;
        stall_cnt_d      = stall_cnt_q;
        flush_cnt_d      = flush_cnt_q;

        if (!rst_i) begin
            unique case (mode_c)
                MODE_MEM_STALL: begin
                    if (Redirect_i) pending_d = 1'b1;
                    stall_cnt_d = stall_cnt_q + CNT_W'(1);
                    if (mstall_cnt_q != MW'(TIMEOUT)) mstall_cnt_d = mstall_cnt_q + MW'(1);
                    else                              mstall_cnt_d = mstall_cnt_q;
                end
                MODE_REDIRECT: begin
                    PC_write_o       = 1'b1;
                    IF_ID_write_o    = 1'b1;
                    ID_EX_write_o    = 1'b1;
                    EX_MEM_write_o   = 1'b1;
                    MEM_WB_write_o   = 1'b1;
                    IF_ID_flush_o    = 1'b1;
                    ID_EX_flush_o    = 1'b1;
                    Redirect_apply_o = 1'b1;
                    pending_d        = 1'b0;
                    flush_cnt_d      = flush_cnt_q + CNT_W'(1);
                end
                MODE_LOAD_USE: begin
                    ID_EX_write_o  = 1'b1;
                    ID_EX_flush_o  = 1'b1;
                    EX_MEM_write_o = 1'b1;
                    MEM_WB_write_o = 1'b1;
                    stall_cnt_d    = stall_cnt_q + CNT_W'(1);
                end
                default: begin
                    PC_write_o     = 1'b1;
                    IF_ID_write_o  = 1'b1;
                    ID_EX_write_o  = 1'b1;
                    EX_MEM_write_o = 1'b1;
                    MEM_WB_write_o = 1'b1;
                end
            endcase
        end

        // Sticky: sets on the edge where the consecutive-stall count hits TIMEOUT.
        timeout_d = timeout_q | (mstall_cnt_d == MW'(TIMEOUT));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pending_q    <= 1'b0;
            mstall_cnt_q <= '0;
            timeout_q    <= 1'b0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
        end else begin
            pending_q    <= pending_d;
            mstall_cnt_q <= mstall_cnt_d;
            timeout_q    <= timeout_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign timeout_o   = timeout_q;
    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed scenarios then random traffic,
// checked against a cycle-level behavioural model of the hazard rules.
module tb_pipe_hazard_ctrl;

    localparam int unsigned TO = 4;
    localparam int unsigned CW = 8;

    typedef struct packed {
        logic          pc, ifid, idex, exmem, memwb;
        logic          ifid_fl, idex_fl, apply, tmo;
        logic [CW-1:0] stall, flush;
    } out_t;

    typedef struct packed {
        logic       rst, memread;
        logic [4:0] rd, rs1, rs2;
        logic       use1, use2, redir, ic, dc;
    } stim_t;

    logic clk = 1'b0;
    logic rst_i, ID_EX_MemRead_i, ID_UseRs1_i, ID_UseRs2_i, Redirect_i;
    logic ICache_stall_i, DCache_stall_i;
    logic [4:0] ID_EX_Rd_i, IF_ID_Rs1_i, IF_ID_Rs2_i;
    logic PC_write_o, IF_ID_write_o, ID_EX_write_o, EX_MEM_write_o, MEM_WB_write_o;
    logic IF_ID_flush_o, ID_EX_flush_o, Redirect_apply_o, timeout_o;
    logic [CW-1:0] stall_cnt_o, flush_cnt_o;

    pipe_hazard_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .ID_EX_MemRead_i(ID_EX_MemRead_i), .ID_EX_Rd_i(ID_EX_Rd_i),
        .IF_ID_Rs1_i(IF_ID_Rs1_i), .IF_ID_Rs2_i(IF_ID_Rs2_i),
        .ID_UseRs1_i(ID_UseRs1_i), .ID_UseRs2_i(ID_UseRs2_i),
        .Redirect_i(Redirect_i),
        .ICache_stall_i(ICache_stall_i), .DCache_stall_i(DCache_stall_i),
        .PC_write_o(PC_write_o), .IF_ID_write_o(IF_ID_write_o),
        .ID_EX_write_o(ID_EX_write_o), .EX_MEM_write_o(EX_MEM_write_o),
        .MEM_WB_write_o(MEM_WB_write_o),
        .IF_ID_flush_o(IF_ID_flush_o), .ID_EX_flush_o(ID_EX_flush_o),
        .Redirect_apply_o(Redirect_apply_o), .timeout_o(timeout_o),
        .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    always #5 clk = ~clk;

    out_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Reference state: plain integers
    int m_pending = 0, m_run = 0, m_tmo = 0, m_stall = 0, m_flush = 0;

    function automatic out_t model_step(input stim_t s);
        out_t e;
        bit   ms, rd, lu;
        e = '0;
        if (s.rst) begin
            m_pending = 0; m_run = 0; m_tmo = 0; m_stall = 0; m_flush = 0;
            return e;
        end
        ms = s.ic || s.dc;
        rd = s.redir || (m_pending != 0);
        lu = s.memread && (s.rd != 0) &&
             ((s.use1 && s.rd == s.rs1) || (s.use2 && s.rd == s.rs2));
        e.tmo   = (m_tmo != 0);
        e.stall = CW'(m_stall);
        e.flush = CW'(m_flush);
        if (ms) begin
            if (s.redir) m_pending = 1;
            m_stall = (m_stall + 1) % (1 << CW);
            m_run   = (m_run < TO) ? m_run + 1 : TO;
            if (m_run == TO) m_tmo = 1;
        end else begin
            m_run = 0;
            if (rd) begin
                {e.pc, e.ifid, e.idex, e.exmem, e.memwb} = 5'b11111;
                {e.ifid_fl, e.idex_fl, e.apply} = 3'b111;
                m_pending = 0;
                m_flush   = (m_flush + 1) % (1 << CW);
            end else if (lu) begin
                {e.idex, e.exmem, e.memwb, e.idex_fl} = 4'b1111;
                m_stall = (m_stall + 1) % (1 << CW);
            end else begin
                {e.pc, e.ifid, e.idex, e.exmem, e.memwb} = 5'b11111;
            end
        end
        return e;
    endfunction

    // Apply one cycle of stimulus and queue its expected response
    task automatic apply(input stim_t s);
        rst_i = s.rst; ID_EX_MemRead_i = s.memread; ID_EX_Rd_i = s.rd;
        IF_ID_Rs1_i = s.rs1; IF_ID_Rs2_i = s.rs2;
        ID_UseRs1_i = s.use1; ID_UseRs2_i = s.use2; Redirect_i = s.redir;
        ICache_stall_i = s.ic; DCache_stall_i = s.dc;
        exp_q.push_back(model_step(s));
        @(posedge clk);
        #1;
    endtask

    function automatic stim_t idle();
        return '0;
    endfunction

    // Monitor: compare at the falling edge, away from the active edge
    initial begin
        out_t a, e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                a = '{PC_write_o, IF_ID_write_o, ID_EX_write_o, EX_MEM_write_o,
                      MEM_WB_write_o, IF_ID_flush_o, ID_EX_flush_o,
                      Redirect_apply_o, timeout_o, stall_cnt_o, flush_cnt_o};
                n_vec++;
                if (a !== e) begin
                    n_bad++;
                    $display("FAIL vec%0d t=%0t outputs got=%h want=%h (pc ifid idex exmem memwb iffl exfl apply tmo stall flush)",
                             n_vec, $time, a, e);
                end
            end
        end
    end

    initial begin
        stim_t s;
        int run_left, run_ic, wait_cyc;
        run_left = 0; run_ic = 0;
        s = idle(); s.rst = 1'b1;
        rst_i = 1'b1; ID_EX_MemRead_i = 0; ID_EX_Rd_i = 0; IF_ID_Rs1_i = 0;
        IF_ID_Rs2_i = 0; ID_UseRs1_i = 0; ID_UseRs2_i = 0; Redirect_i = 0;
        ICache_stall_i = 0; DCache_stall_i = 0;
        @(posedge clk); #1;
        apply(s); apply(s);

        // load-use on rs1, then dependency resolves
        s = idle(); s.memread = 1; s.rd = 5; s.rs1 = 5; s.use1 = 1;
        apply(s); apply(idle());
        // load to x0: no hazard
        s = idle(); s.memread = 1; s.use1 = 1; s.use2 = 1;
        apply(s);
        // rs2 hazard, and rs2 match but unused
        s = idle(); s.memread = 1; s.rd = 7; s.rs2 = 7; s.use2 = 1;
        apply(s);
        s.use2 = 0; apply(s);
        // redirect with simultaneous load-use
        s = idle(); s.redir = 1; s.memread = 1; s.rd = 3; s.rs1 = 3; s.use1 = 1;
        apply(s); apply(idle());
        // redirect during a 5-cycle D-miss, second pulse merged
        for (int i = 1; i <= 5; i++) begin
            s = idle(); s.dc = 1; s.redir = (i == 2 || i == 4);
            apply(s);
        end
        apply(idle()); apply(idle());
        // watchdog: 6 I-miss cycles, then stall clears
        for (int i = 0; i < 6; i++) begin
            s = idle(); s.ic = 1; apply(s);
        end
        apply(idle()); apply(idle());
        // reset in the middle of a stall with a pending redirect
        s = idle(); s.dc = 1; s.redir = 1; apply(s);
        s = idle(); s.dc = 1; apply(s);
        s = idle(); s.rst = 1; apply(s);
        apply(idle()); apply(idle());

        // random traffic with bursty cache misses and occasional reset
        for (int c = 0; c < 3000; c++) begin
            s = idle();
            if (run_left == 0 && $urandom_range(0, 7) == 0) begin
                run_left = $urandom_range(1, 8);
                run_ic   = $urandom_range(0, 1);
            end
            if (run_left > 0) begin
                if (run_ic != 0) s.ic = 1; else s.dc = 1;
                if ($urandom_range(0, 3) == 0) begin s.ic = 1; s.dc = 1; end
                run_left--;
            end
            s.memread = $urandom_range(0, 1) != 0;
            s.rd   = 5'($urandom_range(0, 3));
            s.rs1  = 5'($urandom_range(0, 3));
            s.rs2  = 5'($urandom_range(0, 3));
            s.use1 = $urandom_range(0, 1) != 0;
            s.use2 = $urandom_range(0, 1) != 0;
            s.redir = $urandom_range(0, 9) == 0;
            s.rst   = $urandom_range(0, 299) == 0;
            apply(s);
        end

        wait_cyc = 0;
        while (exp_q.size() != 0 && wait_cyc < 20) begin
            @(posedge clk); wait_cyc++;
        end
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected responses never checked, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
